// File: rtl/snake_body_if.sv
// snake_body_if: game-core control, apple, renderer query and status signals
// shared between the snake body tracker and whatever drives it.
interface snake_body_if;
  logic       start;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic [6:0] apple_x;
  logic [5:0] apple_y;
  logic [6:0] query_x;
  logic [5:0] query_y;
  logic [6:0] head_x;
  logic [5:0] head_y;
  logic [4:0] length;
  logic       ate;
  logic       running;
  logic       game_over;
  logic       query_hit;

  // Driver side: game controller / renderer / test stimulus.
  modport master (
    output start, btn_up, btn_down, btn_left, btn_right,
    output apple_x, apple_y, query_x, query_y,
    input  head_x, head_y, length, ate, running, game_over, query_hit
  );

  // Snake body tracker side.
  modport slave (
    input  start, btn_up, btn_down, btn_left, btn_right,
    input  apple_x, apple_y, query_x, query_y,
    output head_x, head_y, length, ate, running, game_over, query_hit
  );
endinterface

// File: rtl/snake_body.sv
// snake_body: snake movement and body tracker.
// Steps the head one cell per move tick, keeps the body as a shift register
// of cell coordinates, grows on the apple cell and detects wall/self
// collisions. Also answers renderer occupancy queries with one cycle latency.
// Optional build macro SNAKE_WRAP_EN: walls wrap around instead of ending
// the game (only self collision ends it).
module snake_body #(
  parameter int GRID_COLS = 80,
  parameter int GRID_ROWS = 60,
  parameter int MAX_LEN   = 16,
  parameter int STEP_DIV  = 6_500_000
) (
  input  logic         clk,
  input  logic         reset,
  snake_body_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER} state_t;
  typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN} dir_t;

  localparam int             DIV_W    = $clog2(STEP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [7:0]     COLS_W   = 8'(GRID_COLS);
  localparam logic [6:0]     ROWS_W   = 7'(GRID_ROWS);
  localparam logic [4:0]     INIT_LEN = 5'd3;
  localparam logic [4:0]     LEN_MAX  = 5'(MAX_LEN);

  // Initial body: three segments in a row, head at (14,33), facing right.
  function automatic logic [6:0] init_x(input int i);
    return (i < 3) ? 7'(14 - i) : 7'd0;
  endfunction

  function automatic logic [5:0] init_y(input int i);
    return (i < 3) ? 6'd33 : 6'd0;
  endfunction

  function automatic logic is_reverse(input dir_t a, input dir_t b);
    case (a)
      DIR_RIGHT: return b == DIR_LEFT;
      DIR_LEFT:  return b == DIR_RIGHT;
      DIR_UP:    return b == DIR_DOWN;
      default:   return b == DIR_UP;
    endcase
  endfunction

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  dir_t             pend_q, pend_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       len_q, len_d;
  logic [6:0]       seg_x_q [MAX_LEN];
  logic [6:0]       seg_x_d [MAX_LEN];
  logic [5:0]       seg_y_q [MAX_LEN];
  logic [5:0]       seg_y_d [MAX_LEN];
  logic             ate_q, ate_d;
  logic             running_q, running_d;
  logic             over_q, over_d;
  logic             hit_q, hit_d;

  logic             tick;
  logic             req_any;
  dir_t             req_dir;
  dir_t             dir_ref;
  logic signed [7:0] step_x;
  logic signed [6:0] step_y;
  logic             x_lo, x_hi, y_lo, y_hi;
  logic             wall_hit;
  logic             self_hit;
  logic             grow;
  logic [6:0]       next_x;
  logic [5:0]       next_y;

  // Button priority decode and candidate next head for the coming tick.
  always_comb begin
    req_any = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
    if (bus.btn_up)        req_dir = DIR_UP;
    else if (bus.btn_down) req_dir = DIR_DOWN;
    else if (bus.btn_left) req_dir = DIR_LEFT;
    else                   req_dir = DIR_RIGHT;

    tick   = (state_q == ST_RUN) && (div_q == DIV_LAST);
    step_x = $signed({1'b0, seg_x_q[0]});
    step_y = $signed({1'b0, seg_y_q[0]});
    // The move uses the pending direction, which becomes the direction on the tick.
    case (pend_q)
      DIR_RIGHT: step_x = step_x + 8'sd1;
      DIR_LEFT:  step_x = step_x - 8'sd1;
      DIR_UP:    step_y = step_y - 7'sd1;
      default:   step_y = step_y + 7'sd1;
    endcase

    x_lo = step_x[7];
    x_hi = !step_x[7] && ($unsigned(step_x) >= COLS_W);
    y_lo = step_y[6];
    y_hi = !step_y[6] && ($unsigned(step_y) >= ROWS_W);

`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
    if (x_lo)      next_x = 7'(GRID_COLS - 1);
    else if (x_hi) next_x = 7'd0;
    else           next_x = step_x[6:0];
    if (y_lo)      next_y = 6'(GRID_ROWS - 1);
    else if (y_hi) next_y = 6'd0;
    else           next_y = step_y[5:0];
`else
    wall_hit = x_lo | x_hi | y_lo | y_hi;
    next_x   = step_x[6:0];
    next_y   = step_y[5:0];
`endif

    grow = !wall_hit && (next_x == bus.apple_x) && (next_y == bus.apple_y);
  end

  // Body comparisons: self collision against the next head, occupancy for the renderer.
  always_comb begin
    self_hit = 1'b0;
    hit_d    = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      // The tail only counts as an obstacle when it stays put (growing move).
      if ((((5'(i) + 5'd1) < len_q) || (grow && ((5'(i) + 5'd1) == len_q))) &&
          (seg_x_q[i] == next_x) && (seg_y_q[i] == next_y))
        self_hit = 1'b1;
      if ((5'(i) < len_q) && (seg_x_q[i] == bus.query_x) && (seg_y_q[i] == bus.query_y))
        hit_d = 1'b1;
    end
  end

  // Game FSM, direction latch, move divider and body shift register.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    div_d   = div_q;
    len_d   = len_q;
    ate_d   = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_x_d[i] = seg_x_q[i];
      seg_y_d[i] = seg_y_q[i];
    end
    // In the tick cycle the direction is about to become pend_q, so a new
    // request is judged against that rather than the outgoing direction.
    dir_ref = tick ? pend_q : dir_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d = ST_RUN;
          div_d   = '0;
          dir_d   = DIR_RIGHT;
          pend_d  = DIR_RIGHT;
          len_d   = INIT_LEN;
          for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = init_x(i);
            seg_y_d[i] = init_y(i);
          end
        end
      end
      ST_RUN: begin
        if (req_any && !is_reverse(req_dir, dir_ref))
          pend_d = req_dir;
        if (tick) begin
          div_d = '0;
          dir_d = pend_q;
          if (wall_hit || self_hit) begin
            state_d = ST_OVER;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = next_x;
            seg_y_d[0] = next_y;
            if (grow) begin
              ate_d = 1'b1;
              if (len_q != LEN_MAX)
                len_d = len_q + 5'd1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    running_d = (state_d == ST_RUN);
    over_d    = (state_d == ST_OVER);
  end

  // State and output registers; reset restores the initial body.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_RIGHT;
      pend_q    <= DIR_RIGHT;
      div_q     <= '0;
      len_q     <= INIT_LEN;
      ate_q     <= 1'b0;
      running_q <= 1'b0;
      over_q    <= 1'b0;
      hit_q     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= init_y(i);
      end
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      div_q     <= div_d;
      len_q     <= len_d;
      ate_q     <= ate_d;
      running_q <= running_d;
      over_q    <= over_d;
      hit_q     <= hit_d;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= seg_x_d[i];
        seg_y_q[i] <= seg_y_d[i];
      end
    end
  end

  assign bus.head_x    = seg_x_q[0];
  assign bus.head_y    = seg_y_q[0];
  assign bus.length    = len_q;
  assign bus.ate       = ate_q;
  assign bus.running   = running_q;
  assign bus.game_over = over_q;
  assign bus.query_hit = hit_q;

endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: scoreboard bench for snake_body with a fast move tick.
module tb_snake_body;
  localparam int STEP = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  snake_body_if bus();

  snake_body #(
    .GRID_COLS(80),
    .GRID_ROWS(60),
    .MAX_LEN  (16),
    .STEP_DIV (STEP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int hx;
    int hy;
    int len;
    int ate;
    int over;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   phase = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    phase++;
  endtask

  task automatic expect_move(input int hx, input int hy, input int len, input int ate, input int over);
    exp_t e;
    e = '{hx, hy, len, ate, over};
    sb.push_back(e);
  endtask

  // Advance to the end of the current move period and compare against the oldest expectation.
  task automatic do_tick(input string tag);
    exp_t e;
    while (phase < STEP) cycle();
    phase = 0;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
      $fatal(1);
    end
    e = sb.pop_front();
    check_val({tag, "_hx"},   32'(bus.head_x),    e.hx);
    check_val({tag, "_hy"},   32'(bus.head_y),    e.hy);
    check_val({tag, "_len"},  32'(bus.length),    e.len);
    check_val({tag, "_ate"},  32'(bus.ate),       e.ate);
    check_val({tag, "_over"}, 32'(bus.game_over), e.over);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    phase = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    phase = 0;
  endtask

  task automatic query(input string tag, input int qx, input int qy, input int exp);
    bus.query_x = 7'(qx);
    bus.query_y = 6'(qy);
    cycle();
    check_val(tag, 32'(bus.query_hit), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.apple_x   = 7'd0;
    bus.apple_y   = 6'd0;
    bus.query_x   = 7'd0;
    bus.query_y   = 6'd0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Reset state
    check_val("rst_hx",   32'(bus.head_x),    14);
    check_val("rst_hy",   32'(bus.head_y),    33);
    check_val("rst_len",  32'(bus.length),    3);
    check_val("rst_ate",  32'(bus.ate),       0);
    check_val("rst_run",  32'(bus.running),   0);
    check_val("rst_over", 32'(bus.game_over), 0);
    check_val("rst_hit",  32'(bus.query_hit), 0);

    // Occupancy queries on the initial body
    query("q_13_33", 13, 33, 1);
    query("q_40_10", 40, 10, 0);
    query("q_12_33", 12, 33, 1);
    query("q_11_33", 11, 33, 0);
    query("q_14_34", 14, 34, 0);

    // Plain movement to the right
    pulse_start();
    check_val("start_run", 32'(bus.running), 1);
    expect_move(15, 33, 3, 0, 0);
    do_tick("mv1");
    expect_move(16, 33, 3, 0, 0);
    do_tick("mv2");

    // Reverse request is ignored
    bus.btn_left = 1'b1;
    expect_move(17, 33, 3, 0, 0);
    do_tick("rev1");
    expect_move(18, 33, 3, 0, 0);
    do_tick("rev2");
    bus.btn_left = 1'b0;

    // Up has priority over right
    bus.btn_up    = 1'b1;
    bus.btn_right = 1'b1;
    cycle();
    bus.btn_up    = 1'b0;
    bus.btn_right = 1'b0;
    expect_move(18, 32, 3, 0, 0);
    do_tick("prio");

    // start while running leaves the divider and body alone
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    expect_move(18, 31, 3, 0, 0);
    do_tick("start_ign");
    check_val("start_ign_run", 32'(bus.running), 1);

    // Run right into the x=79 column
    bus.btn_right = 1'b1;
    cycle();
    bus.btn_right = 1'b0;
    for (int x = 19; x <= 79; x++) begin
      expect_move(x, 31, 3, 0, 0);
      do_tick("walk");
    end
`ifdef SNAKE_WRAP_EN
    expect_move(0, 31, 3, 0, 0);
    do_tick("wall");
    check_val("wall_run", 32'(bus.running), 1);
    expect_move(1, 31, 3, 0, 0);
    do_tick("wall_after");
`else
    expect_move(79, 31, 3, 0, 1);
    do_tick("wall");
    check_val("wall_run", 32'(bus.running), 0);
    expect_move(79, 31, 3, 0, 1);
    do_tick("wall_after");
`endif

    pulse_reset();
    check_val("rst2_over", 32'(bus.game_over), 0);

    // Grow twice, then curl back into the body
    bus.apple_x = 7'd15;
    bus.apple_y = 6'd33;
    pulse_start();
    expect_move(15, 33, 4, 1, 0);
    do_tick("grow1");
    bus.apple_x = 7'd16;
    bus.query_x = 7'd12;
    bus.query_y = 6'd33;
    cycle();
    check_val("grow1_ate_drop", 32'(bus.ate), 0);
    check_val("grow1_tail_hit", 32'(bus.query_hit), 1);
    query("grow1_q_11_33", 11, 33, 0);
    expect_move(16, 33, 5, 1, 0);
    do_tick("grow2");
    bus.apple_x = 7'd0;
    bus.apple_y = 6'd0;
    bus.btn_up  = 1'b1;
    cycle();
    bus.btn_up  = 1'b0;
    check_val("grow2_ate_drop", 32'(bus.ate), 0);
    expect_move(16, 32, 5, 0, 0);
    do_tick("turn_up");
    bus.btn_left = 1'b1;
    cycle();
    bus.btn_left = 1'b0;
    expect_move(15, 32, 5, 0, 0);
    do_tick("turn_left");
    bus.btn_down = 1'b1;
    cycle();
    bus.btn_down = 1'b0;
    expect_move(15, 32, 5, 0, 1);
    do_tick("self_hit");
    check_val("self_hit_run", 32'(bus.running), 0);

    // Restart from game over
    pulse_start();
    check_val("restart_run",  32'(bus.running),   1);
    check_val("restart_over", 32'(bus.game_over), 0);
    check_val("restart_hx",   32'(bus.head_x),    14);
    check_val("restart_hy",   32'(bus.head_y),    33);
    check_val("restart_len",  32'(bus.length),    3);

    // Request only during the tick cycle takes effect one tick later
    while (phase < STEP - 1) cycle();
    bus.btn_down = 1'b1;
    cycle();
    bus.btn_down = 1'b0;
    expect_move(15, 33, 3, 0, 0);
    do_tick("late_req1");
    expect_move(15, 34, 3, 0, 0);
    do_tick("late_req2");

    // Reset in the middle of a game
    cycle();
    pulse_reset();
    check_val("midrst_run",  32'(bus.running),   0);
    check_val("midrst_over", 32'(bus.game_over), 0);
    check_val("midrst_hx",   32'(bus.head_x),    14);
    check_val("midrst_hy",   32'(bus.head_y),    33);
    check_val("midrst_len",  32'(bus.length),    3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_body.md
# snake_body

Snake movement and body tracker for the game core. Steps the snake head one grid cell per move tick in the player-selected direction, keeps the body as a shift register of cell coordinates, grows on reaching the apple cell and flags wall or self collision. It drives the head position consumed by the apple block and answers occupancy queries from the renderer.

## Interface

Parameters:
- GRID_COLS, 80, playfield width in cells; x in 0..GRID_COLS-1, at most 128.
- GRID_ROWS, 60, playfield height in cells; y in 0..GRID_ROWS-1, at most 64.
- MAX_LEN, 16, maximum body length in segments, including the head; range 4..31.
- STEP_DIV, 6_500_000, clk cycles per move tick; at least 2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts or restarts a game.
- btn_up, btn_down, btn_left, btn_right  in  1 each  direction request levels, already synchronised.
- apple_x  in  7  apple cell column.
- apple_y  in  6  apple cell row.
- query_x  in  7  renderer cell column to test.
- query_y  in  6  renderer cell row to test.
- head_x  out  7  head cell column.
- head_y  out  6  head cell row.
- length  out  5  current body length.
- ate  out  1  one-cycle pulse when the head enters the apple cell.
- running  out  1  high in RUN.
- game_over  out  1  high in OVER.
- query_hit  out  1  high when (query_x, query_y) is an occupied segment; registered.

## Operation

- Body storage: seg[0..MAX_LEN-1] holds (x, y) pairs. seg[0] is the head. Only seg[0..length-1] are valid.
- Init body: length 3, seg0 (14,33), seg1 (13,33), seg2 (12,33), direction RIGHT, pending direction RIGHT.
- FSM states:
  - IDLE, the reset state. start moves to RUN.
  - RUN. A wall or self collision on a tick moves to OVER.
  - OVER. start reloads the init body and moves to RUN in the same transition.
- start in RUN is ignored.
- Direction latch, every cycle in RUN:
  - Priority up > down > left > right when several buttons are held.
  - A request that reverses the current direction is ignored.
  - The latest accepted request overwrites the pending direction.
  - On a tick, direction takes the value of the pending direction.
- Tick in RUN:
  - Compute next head = seg0 ± 1 in the selected direction.
  - Set grow = (next head == (apple_x, apple_y)).
- Wall collision: next x < 0, next x ≥ GRID_COLS, next y < 0 or next y ≥ GRID_ROWS. Compute in signed widths one bit wider than the ports.
- Self collision: next head equals any seg[i] with i < length-1. When grow is set, also test seg[length-1], because the tail does not vacate.
- On a collision:
  - Go to OVER.
  - Body, length and head are not updated.
  - ate is not pulsed.
- Otherwise:
  - Shift seg[i] ← seg[i-1] and load seg0 ← next head.
  - If grow is set, pulse ate and increment length, saturating at MAX_LEN. At saturation the tail still vacates.
- query_hit = OR over valid segments of (seg == query), registered.

## Timing

- Reset values:
  - State IDLE, with the init body and direction.
  - head_x = 14, head_y = 33, length = 3.
  - ate = 0, running = 0, game_over = 0, query_hit = 0.
  - Divider = 0.
- Divider counts 0..STEP_DIV-1, only in RUN. It clears on entry to RUN. The tick is the cycle in which the count equals STEP_DIV-1.
- Head, length, ate and the state change are visible on the clock edge that ends the tick cycle. The first tick after start occurs STEP_DIV cycles after RUN is entered.
- ate is high for exactly one cycle per apple.
- query_hit has 1-cycle latency and reflects the body as it stood in the cycle the query was sampled.
- A direction request in the tick cycle itself is applied at the following tick.
- start and reset together: reset wins.

## Configuration

- SNAKE_WRAP_EN defined:
  - Walls wrap around: x GRID_COLS-1 → 0 and 0 → GRID_COLS-1; y likewise.
  - Only self collision ends the game.
- SNAKE_WRAP_EN undefined: wall collision moves the block to OVER as described above.

## Test plan

All scenarios use STEP_DIV=4.
- Reset, then start with no buttons pressed -> after 4 cycles head = (15,33) and length stays 3; after 8 cycles head = (16,33).
- apple = (15,33), start -> at the first tick ate pulses for 1 cycle and length becomes 4; at the next tick the tail does not move back.
- In RUN moving RIGHT, press btn_left -> ignored and head x keeps incrementing. Press btn_up together with btn_right -> up is taken and head y decrements at the next tick.
- Drive the head to x=79 moving RIGHT -> without the macro, the next tick gives game_over = 1 and head stays (79,y). With SNAKE_WRAP_EN, head becomes (0,y).
- Grow to length 5, then turn up, left and down in consecutive ticks -> self collision, game_over = 1. A start pulse then reloads the init body and sets running = 1.
- query (13,33) right after reset -> query_hit = 1 one cycle later; query (40,10) -> 0. Reset asserted mid-RUN -> next cycle in IDLE with head = (14,33).
